shft_deser: RTL and testbench
=============================

SHFT_DESER -- requirements
Module: shft_deser

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits (>=2).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a new frame; samples dir.
REQ-005 dir  input  1  bit order for the frame: 1 = LSB first (right shift), 0 = MSB first (left shift).
REQ-006 din  input  1  serial data bit.
REQ-007 din_vld  input  1  din valid strobe, one bit per asserted cycle.
REQ-008 dout  output  WIDTH  assembled parallel word.
REQ-009 dout_vld  output  1  dout holds a completed frame.
REQ-010 dout_rdy  input  1  consumer accepts dout when dout_vld=1.
REQ-011 busy  output  1  frame in progress (state SHIFT).
REQ-012 frm_err  output  1  one-cycle pulse: frame aborted by restart.
REQ-013 ovr  output  1  sticky overrun flag.
REQ-014 clr_ovr  input  1  synchronous clear of ovr.

Function
REQ-015 FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-016 IDLE: busy=0, dout_vld=0; din_vld ignored; start=1 -> SHIFT, bit count=0, dir latched into dir_q, shift register cleared.
REQ-017 SHIFT, din_vld=1, dir_q=1: sreg <= {din, sreg[WIDTH-1:1]}; count+1.
REQ-018 SHIFT, din_vld=1, dir_q=0: sreg <= {sreg[WIDTH-2:0], din}; count+1.
REQ-019 SHIFT, din_vld=0: sreg and count hold; no timeout.
REQ-020 The WIDTH-th accepted bit -> dout loaded with the final assembled word (including that bit), dout_vld=1 on the next cycle, state DONE; latency = 1 cycle after last din_vld.
REQ-021 start=1 in SHIFT (any din_vld): frame discarded, frm_err=1 for one cycle, restart as in REQ-016 with the new dir; din on that cycle is not captured.
REQ-022 DONE: dout and dout_vld stable until dout_rdy=1; dout_rdy=1 -> dout_vld=0 next cycle, state IDLE.
REQ-023 DONE, dout_rdy=1 and start=1 same cycle -> state SHIFT directly (REQ-016 actions), no idle cycle.
REQ-024 DONE, start=1 with dout_rdy=0 -> start ignored, ovr=1.
REQ-025 DONE, din_vld=1 -> bit discarded, ovr=1; dout unchanged.
REQ-026 ovr stays set until clr_ovr=1 or reset; a set event in the same cycle as clr_ovr wins (ovr=1).
REQ-027 dout_rdy in IDLE/SHIFT has no effect.
REQ-028 dir changes outside the start cycle have no effect on the current frame.
REQ-029 The bit order is the inverse of the team's shift-out register: the same dir value on both ends yields dout equal to the transmitted LD.

Reset
REQ-030 rstn=0 asynchronously: state IDLE, sreg=0, count=0, dir_q=0, dout=0, dout_vld=0, busy=0, frm_err=0, ovr=0.
REQ-031 Reset mid-frame or in DONE discards all data; there is no residual dout_vld after rstn deasserts.

Structure
REQ-032 Shared package shft_pkg holds the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-033 The block is a single module; the bit counter is $clog2(WIDTH+1) bits wide, and no sub-module is used.

Verification
REQ-034 dir=1, start, bits 1,0,1,0,0,1,0,1 on consecutive din_vld -> dout=0xA5, dout_vld one cycle after the 8th bit, busy=0.
REQ-035 dir=0, start, bits 0,0,1,1,1,1,0,0 with din_vld gaps of 0-3 cycles -> dout=0x3C; gaps do not alter the result.
REQ-036 Frame 0xA5 completes while dout_rdy=0 for 5 cycles, with din_vld pulsed and start asserted in DONE -> dout stays 0xA5, ovr=1; clr_ovr -> ovr=0.
REQ-037 start after 4 bits -> frm_err pulse; then 8 bits of 0x81 -> dout=0x81.
REQ-038 rstn low after 5 bits -> all outputs 0; a new full frame of 0xFF -> dout=0xFF.
REQ-039 dout_rdy and start in the same DONE cycle, then 8 bits of 0x5A -> busy the next cycle, no IDLE cycle, dout=0x5A.

Source files
------------

// File: rtl/shft_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shft_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shft_deser_if.sv
// Handshake/data bundle between a serial producer/consumer and shft_deser.
interface shft_deser_if import shft_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             start;
  logic             dir;
  logic             din;
  logic             din_vld;
  logic             dout_rdy;
  logic             clr_ovr;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             busy;
  logic             frm_err;
  logic             ovr;

  modport master (
    output start, dir, din, din_vld, dout_rdy, clr_ovr,
    input  dout, dout_vld, busy, frm_err, ovr
  );

  modport slave (
    input  start, dir, din, din_vld, dout_rdy, clr_ovr,
    output dout, dout_vld, busy, frm_err, ovr
  );
endinterface

// File: rtl/shft_deser.sv
// Serial-in, parallel-out deserializer with selectable bit order, frame
// restart detection and a sticky overrun flag. All outputs are registered.
module shft_deser import shft_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rstn,
  shft_deser_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_vld_q;
  logic             busy_q;
  logic             frm_err_q;
  logic             ovr_q;
  logic             do_start;
  logic             ovr_set;
  logic             last_bit;

  // dir_q=1: LSB arrives first, so bits enter at the top and move right.
  always_comb begin
    sreg_nxt = sreg;
    if (dir_q) sreg_nxt = {bus.din, sreg[WIDTH-1:1]};
    else       sreg_nxt = {sreg[WIDTH-2:0], bus.din};
  end

  // A start in DONE only counts when the pending word is consumed that cycle.
  always_comb begin
    do_start = 1'b0;
    ovr_set  = 1'b0;
    case (state)
      IDLE:    do_start = bus.start;
      SHIFT:   do_start = bus.start;
      DONE: begin
        do_start = bus.start & bus.dout_rdy;
        ovr_set  = bus.din_vld | (bus.start & ~bus.dout_rdy);
      end
      default: ;
    endcase
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dir_q      <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      frm_err_q <= 1'b0;
      ovr_q     <= (ovr_q & ~bus.clr_ovr) | ovr_set;
      if (do_start) begin
        state      <= SHIFT;
        sreg       <= '0;
        cnt        <= '0;
        dir_q      <= bus.dir;
        busy_q     <= 1'b1;
        dout_vld_q <= 1'b0;
        frm_err_q  <= (state == SHIFT);
      end else begin
        case (state)
          SHIFT: if (bus.din_vld) begin
            sreg <= sreg_nxt;
            if (last_bit) begin
              dout_q     <= sreg_nxt;
              dout_vld_q <= 1'b1;
              busy_q     <= 1'b0;
              cnt        <= '0;
              state      <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DONE: if (bus.dout_rdy) begin
            dout_vld_q <= 1'b0;
            state      <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.busy     = busy_q;
  assign bus.frm_err  = frm_err_q;
  assign bus.ovr      = ovr_q;

endmodule

// File: tb/tb_shft_deser.sv
// Directed checks of shft_deser: bit order, gaps, overrun, restart, reset, back-to-back frames.
module tb_shft_deser;
  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   fails = 0;

  shft_deser_if #(.WIDTH(8)) bus ();
  shft_deser #(.WIDTH(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.din     = b;
    bus.din_vld = 1'b1;
    step();
    bus.din_vld = 1'b0;
    bus.din     = 1'b0;
  endtask

  // Sends the first n bits of w in the requested transmit order.
  task automatic send_bits(input logic [7:0] w, input logic lsb_first, input int n);
    for (int i = 0; i < n; i++) send_bit(lsb_first ? w[i] : w[7-i]);
  endtask

  task automatic begin_frame(input logic d);
    bus.dir   = d;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic accept;
    bus.dout_rdy = 1'b1;
    step();
    bus.dout_rdy = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, {24'd0, bus.dout}, 32'h0);
    chk({tag, "_vld"},  {31'd0, bus.dout_vld}, 32'h0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'h0);
    chk({tag, "_ferr"}, {31'd0, bus.frm_err}, 32'h0);
    chk({tag, "_ovr"},  {31'd0, bus.ovr}, 32'h0);
  endtask

  initial begin
    logic [7:0] w3c;
    rstn = 1'b0;
    bus.start = 1'b0; bus.dir = 1'b0; bus.din = 1'b0; bus.din_vld = 1'b0;
    bus.dout_rdy = 1'b0; bus.clr_ovr = 1'b0;
    #12;
    chk_all_zero("rst");
    step(); step();
    rstn = 1'b1;
    step();

    // LSB-first 0xA5, consecutive bits
    begin_frame(1'b1);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    send_bits(8'hA5, 1'b1, 7);
    chk("t1_vld_early", {31'd0, bus.dout_vld}, 32'd0);
    send_bit(1'b1);
    chk("t1_dout", {24'd0, bus.dout}, 32'hA5);
    chk("t1_vld", {31'd0, bus.dout_vld}, 32'd1);
    chk("t1_busy_end", {31'd0, bus.busy}, 32'd0);
    accept();
    chk("t1_vld_clr", {31'd0, bus.dout_vld}, 32'd0);

    // MSB-first 0x3C with gaps; dir wiggles mid-frame
    w3c = 8'h3C;
    begin_frame(1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (i % 4) begin bus.dir = ~bus.dir; step(); end
      send_bit(w3c[7-i]);
    end
    chk("t2_dout", {24'd0, bus.dout}, 32'h3C);
    chk("t2_vld", {31'd0, bus.dout_vld}, 32'd1);
    accept();

    // Overrun while DONE with dout_rdy low
    begin_frame(1'b1);
    send_bits(8'hA5, 1'b1, 8);
    bus.din = 1'b0; bus.din_vld = 1'b1; step(); bus.din_vld = 1'b0;
    chk("t3_ovr_din", {31'd0, bus.ovr}, 32'd1);
    chk("t3_dout_hold", {24'd0, bus.dout}, 32'hA5);
    bus.clr_ovr = 1'b1; step(); bus.clr_ovr = 1'b0;
    chk("t3_ovr_clr", {31'd0, bus.ovr}, 32'd0);
    bus.dir = 1'b0; bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("t3_ovr_start", {31'd0, bus.ovr}, 32'd1);
    chk("t3_busy", {31'd0, bus.busy}, 32'd0);
    chk("t3_vld", {31'd0, bus.dout_vld}, 32'd1);
    bus.clr_ovr = 1'b1; bus.din_vld = 1'b1; step(); bus.clr_ovr = 1'b0; bus.din_vld = 1'b0;
    chk("t3_set_wins", {31'd0, bus.ovr}, 32'd1);
    step();
    chk("t3_dout_5cyc", {24'd0, bus.dout}, 32'hA5);
    bus.clr_ovr = 1'b1; step(); bus.clr_ovr = 1'b0;
    chk("t3_ovr_clr2", {31'd0, bus.ovr}, 32'd0);
    accept();

    // Restart after 4 bits; din on the restart cycle is dropped
    begin_frame(1'b0);
    send_bits(8'hFF, 1'b0, 4);
    bus.dir = 1'b1; bus.start = 1'b1; bus.din = 1'b1; bus.din_vld = 1'b1;
    step();
    bus.start = 1'b0; bus.din_vld = 1'b0; bus.din = 1'b0;
    chk("t4_ferr", {31'd0, bus.frm_err}, 32'd1);
    chk("t4_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("t4_ferr_pulse", {31'd0, bus.frm_err}, 32'd0);
    send_bits(8'h81, 1'b1, 8);
    chk("t4_dout", {24'd0, bus.dout}, 32'h81);
    chk("t4_vld", {31'd0, bus.dout_vld}, 32'd1);
    chk("t4_no_ovr", {31'd0, bus.ovr}, 32'd0);
    accept();

    // Asynchronous reset mid-frame
    begin_frame(1'b0);
    send_bits(8'hFF, 1'b0, 5);
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    step();
    rstn = 1'b1;
    step();
    chk("t5_vld_after", {31'd0, bus.dout_vld}, 32'd0);
    begin_frame(1'b0);
    send_bits(8'hFF, 1'b0, 8);
    chk("t5_dout", {24'd0, bus.dout}, 32'hFF);
    chk("t5_vld", {31'd0, bus.dout_vld}, 32'd1);

    // Accept and restart in the same DONE cycle
    bus.dout_rdy = 1'b1; bus.start = 1'b1; bus.dir = 1'b1;
    step();
    bus.dout_rdy = 1'b0; bus.start = 1'b0;
    chk("t6_busy", {31'd0, bus.busy}, 32'd1);
    chk("t6_vld", {31'd0, bus.dout_vld}, 32'd0);
    send_bits(8'h5A, 1'b1, 8);
    chk("t6_dout", {24'd0, bus.dout}, 32'h5A);
    chk("t6_vld_end", {31'd0, bus.dout_vld}, 32'd1);
    accept();
    chk("t6_vld_clr", {31'd0, bus.dout_vld}, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
